// File: rtl/id_ex_forward_stage_pkg.sv
// Shared definitions for the ID/EX stage register and its operand forwarding.
// ALU opcodes, ex_ctrl bit positions and the forward-source select encoding.
package id_ex_forward_stage_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ex_ctrl = {alu_src, mem_read, mem_write, reg_write, mem_to_reg, branch}
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_MEM_READ   = 4;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_REG_WRITE  = 2;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_BRANCH     = 0;
    localparam int CTRL_W          = 6;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

endpackage

// File: rtl/id_ex_forward_stage_forward_unit.sv
// Per-operand forwarding mux: picks the youngest in-flight producer of rs,
// falling back to the captured register-file value. x0 is never forwarded.
module forward_unit
    import id_ex_forward_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [XLEN-1:0] rf_data,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_wb_data,
    output logic [XLEN-1:0] data
);

    fwd_sel_t sel;

    // EX/MEM is checked first so the younger result wins on a double match.
    always_comb begin
        sel = FWD_RF;
        if (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs)) begin
            sel = FWD_EXMEM;
        end else if (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs)) begin
            sel = FWD_MEMWB;
        end
    end

    always_comb begin
        data = rf_data;
        case (sel)
            FWD_EXMEM: data = exmem_result;
            FWD_MEMWB: data = memwb_wb_data;
            default:   data = rf_data;
        endcase
    end

endmodule

// File: rtl/id_ex_forward_stage.sv
// ID/EX pipeline register with load-use stall detection, flush, and
// EX/MEM + MEM/WB operand forwarding into the ALU and store-data paths.
module id_ex_forward_stage
    import id_ex_forward_stage_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int REGW = 5
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alu_op,
    input  logic [5:0]      id_ctrl,
    input  logic            flush,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_wb_data,
    output logic            stall_if_id,
    output logic            ex_valid,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_op,
    output logic [XLEN-1:0] ex_store_data,
    output logic [REGW-1:0] ex_rd,
    output logic [5:0]      ex_ctrl
);

    logic [REGW-1:0] ex_rs1;
    logic [REGW-1:0] ex_rs2;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_bubble;

    // Handshake: id_valid marks a decode-stage instruction; stall_if_id is the
    // backpressure. While stall_if_id=1 the instruction is not consumed and the
    // decoder must present it unchanged on the next cycle.
    always_comb begin
        stall_if_id = id_valid && ex_valid && ex_ctrl[CTRL_MEM_READ] &&
                      (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    end

    assign load_bubble = !reset_n || flush || stall_if_id || !id_valid;

    // Bubbles also clear the source indices so a bubble never triggers forwarding.
    always_ff @(posedge clk) begin
        if (load_bubble) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_rd       <= '0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            alu_op      <= ALU_ADD;
            ex_rs1_data <= '0;
            ex_rs2_data <= '0;
            ex_imm      <= '0;
        end else begin
            ex_valid    <= 1'b1;
            ex_ctrl     <= id_ctrl;
            ex_rd       <= id_rd;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            alu_op      <= id_alu_op;
            ex_rs1_data <= id_rs1_data;
            ex_rs2_data <= id_rs2_data;
            ex_imm      <= id_imm;
        end
    end

    forward_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs1 (
        .rs              (ex_rs1),
        .rf_data         (ex_rs1_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_wb_data   (memwb_wb_data),
        .data            (fwd_rs1)
    );

    forward_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd_rs2 (
        .rs              (ex_rs2),
        .rf_data         (ex_rs2_data),
        .exmem_rd        (exmem_rd),
        .exmem_reg_write (exmem_reg_write),
        .exmem_result    (exmem_result),
        .memwb_rd        (memwb_rd),
        .memwb_reg_write (memwb_reg_write),
        .memwb_wb_data   (memwb_wb_data),
        .data            (fwd_rs2)
    );

    always_comb begin
        alu_a         = fwd_rs1;
        alu_b         = ex_ctrl[CTRL_ALU_SRC] ? ex_imm : fwd_rs2;
        ex_store_data = fwd_rs2;
    end

endmodule

// File: tb/tb_id_ex_forward_stage.sv
// Scoreboard bench for id_ex_forward_stage: directed hazard scenarios then
// random traffic, checked against a transaction-level pipeline model.
module tb_id_ex_forward_stage;

    localparam int XLEN = 64;
    localparam int REGW = 5;

    typedef struct packed {
        logic            reset_n;
        logic            id_valid;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [XLEN-1:0] imm;
        logic [3:0]      op;
        logic [5:0]      ctrl;
        logic            flush;
        logic [REGW-1:0] exmem_rd;
        logic            exmem_we;
        logic [XLEN-1:0] exmem_res;
        logic [REGW-1:0] memwb_rd;
        logic            memwb_we;
        logic [XLEN-1:0] memwb_data;
    } stim_t;

    // What the EX stage currently holds, as an instruction record.
    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rs1;
        logic [REGW-1:0] rs2;
        logic [REGW-1:0] rd;
        logic [XLEN-1:0] d1;
        logic [XLEN-1:0] d2;
        logic [XLEN-1:0] imm;
        logic [3:0]      op;
        logic [5:0]      ctrl;
    } instr_t;

    typedef struct packed {
        logic            stall;
        logic            valid;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [XLEN-1:0] store;
        logic [REGW-1:0] rd;
        logic [5:0]      ctrl;
    } exp_t;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_n;
    logic            id_valid;
    logic [REGW-1:0] id_rs1, id_rs2, id_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic [3:0]      id_alu_op;
    logic [5:0]      id_ctrl;
    logic            flush;
    logic [REGW-1:0] exmem_rd;
    logic            exmem_reg_write;
    logic [XLEN-1:0] exmem_result;
    logic [REGW-1:0] memwb_rd;
    logic            memwb_reg_write;
    logic [XLEN-1:0] memwb_wb_data;
    logic            stall_if_id, ex_valid;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
    logic [3:0]      alu_op;
    logic [REGW-1:0] ex_rd;
    logic [5:0]      ex_ctrl;

    id_ex_forward_stage #(.XLEN(XLEN), .REGW(REGW)) dut (
        .clk(clk), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alu_op(id_alu_op), .id_ctrl(id_ctrl), .flush(flush),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_wb_data(memwb_wb_data),
        .stall_if_id(stall_if_id), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl)
    );

    int tests_run = 0;
    int tests_failed = 0;
    exp_t exp_q[$];
    instr_t ex_model;

    localparam logic [5:0] C_ALU  = 6'b000100;
    localparam logic [5:0] C_LD   = 6'b110110;
    localparam logic [5:0] C_ST   = 6'b101000;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;

    function automatic instr_t bubble();
        instr_t b;
        b = '0;
        b.op = OP_ADD;
        return b;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.reset_n = 1'b1;
        return s;
    endfunction

    // Youngest writer of a nonzero register supplies its value.
    function automatic logic [XLEN-1:0] operand(logic [REGW-1:0] rs, logic [XLEN-1:0] d, stim_t s);
        if (rs == 0) return d;
        if (s.exmem_we && s.exmem_rd == rs) return s.exmem_res;
        if (s.memwb_we && s.memwb_rd == rs) return s.memwb_data;
        return d;
    endfunction

    function automatic logic is_load_use(stim_t s, instr_t ex);
        return s.id_valid && ex.valid && ex.ctrl[4] && ex.rd != 0 &&
               (ex.rd == s.rs1 || ex.rd == s.rs2);
    endfunction

    // driver: apply at negedge, predict, then advance the model at posedge
    task automatic run(input stim_t s);
        exp_t e;
        instr_t nxt;
        @(negedge clk);
        reset_n = s.reset_n; id_valid = s.id_valid;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
        id_rs1_data = s.d1; id_rs2_data = s.d2; id_imm = s.imm;
        id_alu_op = s.op; id_ctrl = s.ctrl; flush = s.flush;
        exmem_rd = s.exmem_rd; exmem_reg_write = s.exmem_we; exmem_result = s.exmem_res;
        memwb_rd = s.memwb_rd; memwb_reg_write = s.memwb_we; memwb_wb_data = s.memwb_data;
        e.stall = is_load_use(s, ex_model);
        e.valid = ex_model.valid;
        e.a     = operand(ex_model.rs1, ex_model.d1, s);
        e.store = operand(ex_model.rs2, ex_model.d2, s);
        e.b     = ex_model.ctrl[5] ? ex_model.imm : e.store;
        e.op    = ex_model.op;
        e.rd    = ex_model.rd;
        e.ctrl  = ex_model.ctrl;
        exp_q.push_back(e);
        if (!s.reset_n || s.flush || e.stall || !s.id_valid) begin
            nxt = bubble();
        end else begin
            nxt = '{1'b1, s.rs1, s.rs2, s.rd, s.d1, s.d2, s.imm, s.op, s.ctrl};
        end
        @(posedge clk);
        ex_model = nxt;
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] expv);
        tests_run++;
        if (act !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // monitor / scoreboard
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall_if_id",   64'(stall_if_id),   64'(e.stall));
            chk("ex_valid",      64'(ex_valid),      64'(e.valid));
            chk("alu_a",         alu_a,              e.a);
            chk("alu_b",         alu_b,              e.b);
            chk("alu_op",        64'(alu_op),        64'(e.op));
            chk("ex_store_data", ex_store_data,      e.store);
            chk("ex_rd",         64'(ex_rd),         64'(e.rd));
            chk("ex_ctrl",       64'(ex_ctrl),       64'(e.ctrl));
        end
    end

    initial begin
        stim_t s;
        stim_t ld;
        reset_n = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
        id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_alu_op = '0; id_ctrl = '0;
        flush = 1'b0; exmem_rd = '0; exmem_reg_write = 1'b0; exmem_result = '0;
        memwb_rd = '0; memwb_reg_write = 1'b0; memwb_wb_data = '0;
        repeat (2) @(posedge clk);
        ex_model = bubble();

        // reset state observed while reset is still asserted
        s = idle(); s.reset_n = 1'b0; run(s);

        // back-to-back: ADD x5 then SUB x6,x5,x1 with EX/MEM carrying x5=0x10
        s = idle(); s.id_valid = 1; s.rd = 5; s.rs1 = 2; s.rs2 = 3; s.op = OP_ADD; s.ctrl = C_ALU;
        s.d1 = 64'h3; s.d2 = 64'h4; run(s);
        s = idle(); s.id_valid = 1; s.rd = 6; s.rs1 = 5; s.rs2 = 1; s.op = OP_SUB; s.ctrl = C_ALU;
        s.d1 = 64'h0; s.d2 = 64'h1; run(s);
        s = idle(); s.exmem_rd = 5; s.exmem_we = 1; s.exmem_res = 64'h10; run(s);

        // double match on x7
        s = idle(); s.id_valid = 1; s.rd = 8; s.rs1 = 7; s.rs2 = 7; s.op = OP_ADD; s.ctrl = C_ALU;
        s.d1 = 64'h1; s.d2 = 64'h1; run(s);
        s = idle(); s.exmem_rd = 7; s.exmem_we = 1; s.exmem_res = 64'hAA;
        s.memwb_rd = 7; s.memwb_we = 1; s.memwb_data = 64'hBB; run(s);

        // load-use: LD x3 then a consumer of x3, held through the stall
        ld = idle(); ld.id_valid = 1; ld.rd = 3; ld.rs1 = 2; ld.imm = 64'h20; ld.op = OP_ADD; ld.ctrl = C_LD;
        run(ld);
        s = idle(); s.id_valid = 1; s.rd = 4; s.rs1 = 3; s.rs2 = 2; s.op = OP_ADD; s.ctrl = C_ALU;
        s.d1 = 64'h9; s.d2 = 64'h5; run(s); run(s);
        run(idle());

        // x0 must not be forwarded
        s = idle(); s.id_valid = 1; s.rd = 1; s.rs1 = 0; s.rs2 = 0; s.op = OP_ADD; s.ctrl = C_ALU; run(s);
        s = idle(); s.exmem_rd = 0; s.exmem_we = 1; s.exmem_res = 64'hFFFF;
        s.memwb_rd = 0; s.memwb_we = 1; s.memwb_data = 64'h1234; run(s);

        // flush together with stall, then a store with forwarded rs2
        run(ld);
        s = idle(); s.id_valid = 1; s.rd = 4; s.rs1 = 3; s.rs2 = 3; s.op = OP_ADD; s.ctrl = C_ALU;
        s.flush = 1; run(s);
        s = idle(); s.id_valid = 1; s.rd = 0; s.rs1 = 2; s.rs2 = 9; s.imm = 64'h8; s.op = OP_ADD;
        s.ctrl = C_ST; s.d1 = 64'h100; s.d2 = 64'h0; run(s);
        s = idle(); s.exmem_rd = 9; s.exmem_we = 1; s.exmem_res = 64'h55; run(s);

        // reset for one edge while stalled
        run(ld);
        s = idle(); s.id_valid = 1; s.rd = 4; s.rs1 = 3; s.rs2 = 1; s.op = OP_SUB; s.ctrl = C_ALU;
        s.reset_n = 1'b0; run(s);
        s.reset_n = 1'b1; run(s);
        run(idle());

        // random traffic over a small register window to provoke hazards
        for (int i = 0; i < 400; i++) begin
            s = idle();
            s.reset_n    = ($urandom_range(0, 49) != 0);
            s.id_valid   = ($urandom_range(0, 9) != 0);
            s.flush      = ($urandom_range(0, 9) == 0);
            s.rs1        = REGW'($urandom_range(0, 7));
            s.rs2        = REGW'($urandom_range(0, 7));
            s.rd         = REGW'($urandom_range(0, 7));
            s.d1         = {$urandom, $urandom};
            s.d2         = {$urandom, $urandom};
            s.imm        = {$urandom, $urandom};
            s.op         = 4'($urandom_range(0, 15));
            s.ctrl       = ($urandom_range(0, 2) == 0) ? C_LD : 6'($urandom_range(0, 63));
            s.exmem_rd   = REGW'($urandom_range(0, 7));
            s.exmem_we   = 1'($urandom_range(0, 1));
            s.exmem_res  = {$urandom, $urandom};
            s.memwb_rd   = REGW'($urandom_range(0, 7));
            s.memwb_we   = 1'($urandom_range(0, 1));
            s.memwb_data = {$urandom, $urandom};
            run(s);
        end

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
